trees_stream: RTL and testbench
===============================

// Module: trees_stream
// PURPOSE
//  Streaming tree-ensemble inference engine; successor to the single-shot trees core. Walks N_TREES binary trees
//  per sample from on-chip node memory, summing (MODE=0) or per-class accumulating (MODE=1) leaf values.
//  Ping-pong feature banks let the host load sample k+1 while sample k is evaluated. valid/ready on input and result.
// PARAMETERS
//  N_TREES    128  trees per ensemble
//  N_NODES    256  node slots per tree (<=256; child fields 8 bit)
//  N_FEATURE  32   float32 features per sample (even, <=256)
//  MAX_DEPTH  16   max node visits per tree before abort
//  MODE       0    0=regression sum, 1=classification argmax
//  N_CLASSES  4    class accumulators (MODE=1 only, <=256)
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      synchronous, active-high reset
//  load_trees     in   1      write tree_nodes to node mem[n_tree][n_node]
//  n_tree         in   clog2(N_TREES)   tree index
//  n_node         in   clog2(N_NODES)   node index
//  tree_nodes     in   64     node word
//  load_features  in   1      write features2 into shadow bank
//  n_feature      in   clog2(N_FEATURE) even feature index; [31:0]->f[n], [63:32]->f[n+1]
//  features2      in   64     two float32 features
//  feat_valid     in   1      shadow bank complete
//  feat_ready     out  1      shadow bank empty
//  res_valid      out  1      result available
//  res_ready      in   1      result consumed
//  prediction     out  32s    sum (MODE0) / winning class score (MODE1)
//  pred_class     out  8      winning class (MODE1; 0 in MODE0)
//  depth_err      out  1      >=1 tree aborted at MAX_DEPTH for this result
// BEHAVIOUR
//  Node word: split: [63:32] float32 threshold, [31:24] feature idx, [23:16] left, [15:8] right, [0]=0.
//             leaf : [63:32] signed int32 value, [15:8] class id, [0]=1. Root of every tree is node 0.
//  Compare: key(x)= x[31] ? ~x : x^32'h8000_0000; go left iff key(f)<key(thr), else right. -0.0 < +0.0; NaN by key.
//  Reset: feat_ready=1, res_valid=0, prediction=0, pred_class=0, depth_err=0, both banks empty, FSM=IDLE.
//   Node memory not cleared.
//  load_trees honoured only in IDLE; ignored otherwise. load_features ignored while shadow full (feat_ready=0).
//  feat_valid&&feat_ready at edge t -> shadow full, feat_ready=0 from t+1.
//  FSM: IDLE -> (shadow full) swap banks, clear accums/depth_err, tree=0, node=0, feat_ready=1 -> FETCH
//   FETCH: registered read of mem[tree][node] -> EVAL
//   EVAL split: node<=child, visits++; visits==MAX_DEPTH -> abort tree (contributes 0, depth_err=1)
//        else -> FETCH
//   EVAL leaf/abort: accumulate; tree==N_TREES-1 -> RESULT else tree++, node=0, visits=0 -> FETCH
//   RESULT: res_valid=1, outputs stable until res_valid&&res_ready; then shadow full -> swap -> FETCH, else IDLE.
//  Timing: 2 cycles per node visited; res_valid rises cycle after last EVAL. Back-to-back: next FETCH 1 cycle
//   after result handshake.
//  Arithmetic: 32-bit signed accumulate, saturating at 0x7FFFFFFF / 0x80000000.
//  MODE1: leaf adds to acc[class]; class>=N_CLASSES ignored. Argmax ties -> lowest index.
//  Simultaneous: feat_valid in the cycle RESULT completes is accepted; swap happens next cycle.
//  rst mid-sample: computation dropped, no result emitted, state as reset.
// TESTING
//  1 tree, root f0<1.0 -> leaf 5 / else leaf -3; f0=0.5 -> prediction=5; f0=2.0 -> -3; res_valid 4 cycles after FETCH.
//  MODE0, 128 trees each single leaf 0x7FFFFFF0 -> prediction saturates 0x7FFFFFFF, depth_err=0.
//  Tree with cyclic split (left=right=0), MAX_DEPTH=16 -> that tree adds 0, depth_err=1, others still summed.
//  MODE1, leaves class 2 (+4) and class 1 (+4) tie -> pred_class=1, prediction=4; class id 9 leaf ignored.
//  Ping-pong: load sample B during A, hold res_ready=0 10 cycles -> A result stable, B starts 1 cycle after handshake.
//  Compare edges: f=-0.0 vs thr=+0.0 -> left; f=thr exactly -> right; rst during EVAL -> res_valid stays 0, feat_ready=1.

Source files
------------

// File: rtl/trees_stream.sv
`default_nettype none
// ============================================================================
// Module   : trees_stream
// Brief    : Streaming tree-ensemble inference engine. Walks N_TREES binary
//            trees per sample from on-chip node memory and either sums leaf
//            values (MODE=0) or accumulates them per class and reports the
//            argmax (MODE=1). Ping-pong feature banks let the next sample load
//            while the current one is evaluated.
// Revision : 1.0 - initial release
// ============================================================================
module trees_stream #(
    parameter int N_TREES   = 128,
    parameter int N_NODES   = 256,
    parameter int N_FEATURE = 32,
    parameter int MAX_DEPTH = 16,
    parameter int MODE      = 0,
    parameter int N_CLASSES = 4,
    localparam int TW = (N_TREES > 1)   ? $clog2(N_TREES)   : 1,
    localparam int NW = (N_NODES > 1)   ? $clog2(N_NODES)   : 1,
    localparam int FW = (N_FEATURE > 1) ? $clog2(N_FEATURE) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_trees,
    input  logic [TW-1:0]      n_tree,
    input  logic [NW-1:0]      n_node,
    input  logic [63:0]        tree_nodes,
    input  logic               load_features,
    input  logic [FW-1:0]      n_feature,
    input  logic [63:0]        features2,
    input  logic               feat_valid,
    output logic               feat_ready,
    output logic               res_valid,
    input  logic               res_ready,
    output logic signed [31:0] prediction,
    output logic [7:0]         pred_class,
    output logic               depth_err
);

    localparam int VW = $clog2(MAX_DEPTH + 1);
    localparam int CW = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;

    localparam logic [TW-1:0] c_last_tree = TW'(N_TREES - 1);
    localparam logic [VW-1:0] c_max_depth = VW'(MAX_DEPTH);
    localparam logic [8:0]    c_n_classes = 9'(N_CLASSES);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_fetch  = 2'd1;
    localparam logic [1:0] c_st_eval   = 2'd2;
    localparam logic [1:0] c_st_result = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [63:0]        r_mem [N_TREES][N_NODES];
    logic [31:0]        r_bank [2][N_FEATURE];
    logic               r_act;
    logic               r_shadow_full;
    logic [TW-1:0]      r_tree;
    logic [NW-1:0]      r_node;
    logic [VW-1:0]      r_visits;
    logic [63:0]        r_word;
    logic signed [31:0] r_acc [N_CLASSES];
    logic               r_depth_err;

    logic               w_swap;
    logic               w_is_leaf;
    logic               w_go_left;
    logic               w_abort;
    logic               w_tree_done;
    logic               w_last_tree;
    logic [31:0]        w_feat;
    logic [VW-1:0]      w_visits_inc;
    logic [7:0]         w_cls;
    logic signed [31:0] w_best;
    logic [CW-1:0]      w_best_idx;
    logic               w_unused;

    // Order-preserving map of float32 onto unsigned integers (-0.0 sorts below +0.0)
    function automatic logic [31:0] f_key(input logic [31:0] x);
        f_key = x[31] ? ~x : (x ^ 32'h8000_0000);
    endfunction

    // 32-bit signed add clamped to the representable range
    function automatic logic signed [31:0] f_sat_add(input logic signed [31:0] a,
                                                     input logic signed [31:0] b);
        logic signed [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31])
            f_sat_add = s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        else
            f_sat_add = s[31:0];
    endfunction

    assign w_is_leaf    = r_word[0];
    assign w_feat       = r_bank[r_act][r_word[24 +: FW]];
    assign w_go_left    = f_key(w_feat) < f_key(r_word[63:32]);
    assign w_visits_inc = r_visits + VW'(1);
    assign w_abort      = !w_is_leaf && (w_visits_inc == c_max_depth);
    assign w_tree_done  = w_is_leaf || w_abort;
    assign w_last_tree  = (r_tree == c_last_tree);
    assign w_cls        = r_word[15:8];
    // Bank swap: start a new sample from IDLE, or straight out of a consumed result
    assign w_swap       = r_shadow_full &&
                          ((r_state == c_st_idle) || ((r_state == c_st_result) && res_ready));
    assign w_unused     = ^{r_word, n_feature[0]};

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= c_st_idle;
        else
            r_state <= w_state_next;
    end

    // FSM next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:   if (r_shadow_full) w_state_next = c_st_fetch;
            c_st_fetch:  w_state_next = c_st_eval;
            c_st_eval:   w_state_next = (w_tree_done && w_last_tree) ? c_st_result : c_st_fetch;
            c_st_result: if (res_ready) w_state_next = r_shadow_full ? c_st_fetch : c_st_idle;
            default:     w_state_next = c_st_idle;
        endcase
    end

    // Node memory: host writes only while idle; registered read during FETCH
    always_ff @(posedge clk) begin
        if (load_trees && (r_state == c_st_idle))
            r_mem[n_tree][n_node] <= tree_nodes;
        if (r_state == c_st_fetch)
            r_word <= r_mem[r_tree][r_node];
    end

    // Shadow feature bank writes, two features per beat
    always_ff @(posedge clk) begin
        if (load_features && !r_shadow_full) begin
            r_bank[~r_act][{n_feature[FW-1:1], 1'b0}] <= features2[31:0];
            r_bank[~r_act][{n_feature[FW-1:1], 1'b1}] <= features2[63:32];
        end
    end

    // Bank control, tree walk pointers and accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act         <= 1'b0;
            r_shadow_full <= 1'b0;
            r_tree        <= '0;
            r_node        <= '0;
            r_visits      <= '0;
            r_depth_err   <= 1'b0;
            for (int i = 0; i < N_CLASSES; i++) r_acc[i] <= '0;
        end else begin
            if (w_swap)
                r_shadow_full <= 1'b0;
            else if (feat_valid)
                r_shadow_full <= 1'b1;

            if (w_swap) begin
                r_act       <= ~r_act;
                r_tree      <= '0;
                r_node      <= '0;
                r_visits    <= '0;
                r_depth_err <= 1'b0;
                for (int i = 0; i < N_CLASSES; i++) r_acc[i] <= '0;
            end else if (r_state == c_st_eval) begin
                if (w_tree_done) begin
                    if (w_is_leaf) begin
                        if (MODE == 0)
                            r_acc[0] <= f_sat_add(r_acc[0], r_word[63:32]);
                        else if ({1'b0, w_cls} < c_n_classes)
                            r_acc[w_cls[CW-1:0]] <= f_sat_add(r_acc[w_cls[CW-1:0]], r_word[63:32]);
                    end else begin
                        r_depth_err <= 1'b1;
                    end
                    if (!w_last_tree) begin
                        r_tree   <= r_tree + TW'(1);
                        r_node   <= '0;
                        r_visits <= '0;
                    end
                end else begin
                    r_node   <= w_go_left ? r_word[16 +: NW] : r_word[8 +: NW];
                    r_visits <= w_visits_inc;
                end
            end
        end
    end

    // Argmax over class accumulators; strict compare keeps the lowest index on ties
    always_comb begin
        w_best     = r_acc[0];
        w_best_idx = '0;
        for (int i = 1; i < N_CLASSES; i++) begin
            if (r_acc[i] > w_best) begin
                w_best     = r_acc[i];
                w_best_idx = CW'(i);
            end
        end
    end

    assign feat_ready = !r_shadow_full;
    assign res_valid  = (r_state == c_st_result);
    assign prediction = (MODE == 0) ? r_acc[0] : w_best;
    assign pred_class = (MODE == 0) ? 8'd0 : 8'(w_best_idx);
    assign depth_err  = r_depth_err;

endmodule
`default_nettype wire

// File: tb/tb_trees_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_trees_stream
// Brief    : Scoreboard bench for trees_stream. A regression (MODE=0) and a
//            classification (MODE=1) instance share all inputs; expected
//            results are queued at sample issue and popped by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trees_stream;

    localparam int NT = 4;

    localparam logic [31:0] c_one   = 32'h3F80_0000;
    localparam logic [31:0] c_half  = 32'h3F00_0000;
    localparam logic [31:0] c_two   = 32'h4000_0000;
    localparam logic [31:0] c_neg1  = 32'hBF80_0000;
    localparam logic [31:0] c_nan   = 32'h7FC0_0000;
    localparam logic [31:0] c_nzero = 32'h8000_0000;
    localparam logic [31:0] c_pzero = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, load_trees, load_features, feat_valid, res_ready;
    logic [1:0]  n_tree;
    logic [7:0]  n_node;
    logic [63:0] tree_nodes;
    logic [4:0]  n_feature;
    logic [63:0] features2;

    logic               feat_ready_r, res_valid_r, depth_err_r;
    logic signed [31:0] prediction_r;
    logic [7:0]         pred_class_r;
    logic               feat_ready_c, res_valid_c, depth_err_c;
    logic signed [31:0] prediction_c;
    logic [7:0]         pred_class_c;

    typedef struct {
        logic [31:0] p0;
        logic        e;
        logic [31:0] p1;
        logic [7:0]  c1;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    trees_stream #(.N_TREES(NT), .MODE(0)) u_reg (
        .clk(clk), .rst(rst), .load_trees(load_trees), .n_tree(n_tree), .n_node(n_node),
        .tree_nodes(tree_nodes), .load_features(load_features), .n_feature(n_feature),
        .features2(features2), .feat_valid(feat_valid), .feat_ready(feat_ready_r),
        .res_valid(res_valid_r), .res_ready(res_ready), .prediction(prediction_r),
        .pred_class(pred_class_r), .depth_err(depth_err_r)
    );

    trees_stream #(.N_TREES(NT), .MODE(1)) u_cls (
        .clk(clk), .rst(rst), .load_trees(load_trees), .n_tree(n_tree), .n_node(n_node),
        .tree_nodes(tree_nodes), .load_features(load_features), .n_feature(n_feature),
        .features2(features2), .feat_valid(feat_valid), .feat_ready(feat_ready_c),
        .res_valid(res_valid_c), .res_ready(res_ready), .prediction(prediction_c),
        .pred_class(pred_class_c), .depth_err(depth_err_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] leaf(input logic [31:0] v, input logic [7:0] c);
        return {v, 16'h0000, c, 8'h01};
    endfunction

    function automatic logic [63:0] split(input logic [31:0] thr, input logic [7:0] f,
                                          input logic [7:0] l, input logic [7:0] r);
        return {thr, f, l, r, 8'h00};
    endfunction

    task automatic wn(input logic [1:0] t, input logic [7:0] n, input logic [63:0] w);
        load_trees = 1'b1; n_tree = t; n_node = n; tree_nodes = w;
        @(posedge clk); #1;
        load_trees = 1'b0;
    endtask

    task automatic send(input logic [31:0] f0, input logic [31:0] f1, input logic [31:0] p0,
                        input logic e, input logic [31:0] p1, input logic [7:0] c1,
                        input bit push);
        int k;
        k = 0;
        while (!feat_ready_r && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("feat_ready_wait", feat_ready_r, 1);
        load_features = 1'b1; n_feature = 5'd0; features2 = {f1, f0};
        @(posedge clk); #1;
        load_features = 1'b0;
        feat_valid = 1'b1;
        if (push) q.push_back('{p0, e, p1, c1});
        @(posedge clk); #1;
        feat_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 600) begin
            @(posedge clk); #1;
            k++;
        end
        check("result_drain", q.size(), 0);
        @(posedge clk); #1;
    endtask

    // Monitor: every accepted result is compared against the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && res_valid_r && res_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %h expected none", prediction_r);
            end else begin
                mon_e = q.pop_front();
                check("pred_reg",  prediction_r, mon_e.p0);
                check("err_reg",   depth_err_r,  mon_e.e);
                check("class_reg", pred_class_r, 0);
                check("valid_cls", res_valid_c,  1);
                check("pred_cls",  prediction_c, mon_e.p1);
                check("class_cls", pred_class_c, mon_e.c1);
                check("err_cls",   depth_err_c,  mon_e.e);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; load_trees = 1'b0; load_features = 1'b0; feat_valid = 1'b0;
        res_ready = 1'b1; n_tree = '0; n_node = '0; tree_nodes = '0;
        n_feature = '0; features2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_feat_ready", feat_ready_r, 1);
        check("rst_res_valid",  res_valid_r,  0);
        check("rst_pred",       prediction_r, 0);
        check("rst_class",      pred_class_r, 0);
        check("rst_err",        depth_err_r,  0);
        check("rst_pred_cls",   prediction_c, 0);
        @(posedge clk); #1;

        // Simple threshold tree plus three zero-leaf trees
        wn(0, 0, split(c_one, 8'd0, 8'd1, 8'd2));
        wn(0, 1, leaf(5, 0));
        wn(0, 2, leaf(-3, 0));
        wn(1, 0, leaf(0, 0));
        wn(2, 0, leaf(0, 0));
        wn(3, 0, leaf(0, 0));
        send(c_half, c_pzero, 5, 0, 5, 0, 1);
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            if (res_valid_r) break;
            n++;
        end
        check("latency_first", n, 11);
        @(posedge clk); #1;
        send(c_two, c_pzero, -3, 0, 0, 1, 1);
        drain();

        // Saturation, positive then negative
        wn(0, 0, leaf(32'h7FFF_FFF0, 0));
        wn(1, 0, leaf(32'h7FFF_FFF0, 0));
        wn(2, 0, leaf(32'h7FFF_FFF0, 0));
        wn(3, 0, leaf(32'h7FFF_FFF0, 0));
        send(c_pzero, c_pzero, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 0, 1);
        drain();
        wn(0, 0, leaf(32'h8000_0010, 0));
        wn(1, 0, leaf(32'h8000_0010, 0));
        wn(2, 0, leaf(32'h8000_0010, 0));
        wn(3, 0, leaf(32'h8000_0010, 0));
        send(c_pzero, c_pzero, 32'h8000_0000, 0, 0, 1, 1);
        drain();

        // Cyclic tree aborts at max depth; other trees still summed
        wn(0, 0, split(c_one, 8'd0, 8'd0, 8'd0));
        wn(1, 0, leaf(7, 0));
        wn(2, 0, leaf(8, 0));
        wn(3, 0, leaf(9, 0));
        send(c_half, c_pzero, 24, 1, 24, 0, 1);
        drain();

        // Class tie resolves to lowest index; out-of-range class ignored
        wn(0, 0, leaf(4, 2));
        wn(1, 0, leaf(4, 1));
        wn(2, 0, leaf(100, 9));
        wn(3, 0, leaf(0, 0));
        send(c_pzero, c_pzero, 108, 0, 4, 1, 1);
        drain();

        // Compare edge cases on two split trees
        wn(0, 0, split(c_pzero, 8'd0, 8'd1, 8'd2));
        wn(0, 1, leaf(10, 0));
        wn(0, 2, leaf(20, 0));
        wn(1, 0, split(c_one, 8'd1, 8'd1, 8'd2));
        wn(1, 1, leaf(100, 0));
        wn(1, 2, leaf(200, 0));
        wn(2, 0, leaf(0, 0));
        wn(3, 0, leaf(0, 0));
        send(c_neg1, c_nan, 210, 0, 210, 0, 1);
        drain();

        // Ping-pong with result back-pressure
        res_ready = 1'b0;
        send(c_nzero, c_one, 210, 0, 210, 0, 1);
        send(c_pzero, c_half, 120, 0, 120, 0, 1);
        n = 0;
        while (!res_valid_r && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("pp_a_valid", res_valid_r, 1);
        check("pp_shadow_full", feat_ready_r, 0);
        repeat (10) begin
            @(negedge clk);
            check("pp_hold_valid", res_valid_r, 1);
            check("pp_hold_pred", prediction_r, 210);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            if (res_valid_r) break;
            n++;
        end
        check("pp_b_latency", n, 12);
        @(posedge clk); #1;
        drain();

        // Reset while evaluating drops the sample
        send(c_neg1, c_nan, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (res_valid_r) n++;
        end
        check("rst_no_result", n, 0);
        check("rst_mid_feat_ready", feat_ready_r, 1);
        @(posedge clk); #1;
        send(c_neg1, c_nan, 210, 0, 210, 0, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
